// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers.
// Used by mix_col_seq and mix_one_col.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_one_col.sv
// Single-column (Inv)MixColumns, purely combinational.
// Optional inverse path under MIX_INV_EN.
module mix_one_col
  import aes_pkg::*;
(
  input  col_t       col,
`ifdef MIX_INV_EN
  input  logic       inv,
`endif
  output col_t       mixed
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
`ifdef MIX_INV_EN
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
`endif

  // Unpack rows, build xtime chain, combine per row.
  always_comb begin
    mixed = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
`ifdef MIX_INV_EN
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
`endif
    end
    for (int i = 0; i < 4; i++) begin
      mixed[31-8*i -: 8] =
        x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^
        a[(i+2)%4] ^ a[(i+3)%4];
`ifdef MIX_INV_EN
      if (inv) begin
        mixed[31-8*i -: 8] =
          (x8[i] ^ x4[i] ^ x2[i]) ^
          (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4]) ^
          (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4]) ^
          (x8[(i+3)%4] ^ a[(i+3)%4]);
      end
`endif
    end
  end

endmodule

// File: rtl/mix_col_seq.sv
// Iterative MixColumns scheduler over COLS_PER_CYC mixers.
// Define MIX_INV_EN to add the inv port (InvMixColumns).
module mix_col_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYC = 1
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef MIX_INV_EN
  input  logic         inv,
`endif
  output logic         busy
);

  localparam int NPASS = 4 / COLS_PER_CYC;
  localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;

  fsm_t          state;
  fsm_t          state_nxt;
  logic [CW-1:0] cnt;
  state_t        src;
  state_t        res;
  logic          last;
`ifdef MIX_INV_EN
  logic          inv_q;
`endif

  logic [1:0] sel      [COLS_PER_CYC];
  col_t       lane_in  [COLS_PER_CYC];
  col_t       lane_out [COLS_PER_CYC];

  assign last     = (cnt == CW'(NPASS - 1));
  assign out_data = res;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Column selection for the current pass.
  always_comb begin
    for (int j = 0; j < COLS_PER_CYC; j++) begin
      sel[j]     = 2'(int'(cnt) * COLS_PER_CYC + j);
      lane_in[j] = src[32*sel[j] +: 32];
    end
  end

  for (genvar j = 0; j < COLS_PER_CYC; j++) begin : g_lane
    mix_one_col u_mix (
      .col   (lane_in[j]),
`ifdef MIX_INV_EN
      .inv   (inv_q),
`endif
      .mixed (lane_out[j])
    );
  end

  // Capture input, then write mixed columns pass by pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      src   <= '0;
      res   <= '0;
`ifdef MIX_INV_EN
      inv_q <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      src   <= in_data;
      cnt   <= '0;
`ifdef MIX_INV_EN
      inv_q <= inv;
`endif
    end else if (state == RUN) begin
      for (int j = 0; j < COLS_PER_CYC; j++)
        res[32*sel[j] +: 32] <= lane_out[j];
      if (!last) cnt <= cnt + 1'b1;
    end
  end

endmodule
